// File: rtl/sha256_round_ctrl_if.sv
// Handshake/data bundle for sha256_round_ctrl.
// The abort signal exists only when SHA256_CTRL_ABORT_EN is defined.
interface sha256_round_ctrl_if;
  logic         start;
  logic         first;
  logic [511:0] block;
  logic         busy;
  logic         done;
  logic [255:0] digest;
`ifdef SHA256_CTRL_ABORT_EN
  logic         abort;

  modport master (output start, first, block, abort, input busy, done, digest);
  modport slave  (input start, first, block, abort, output busy, done, digest);
`else
  modport master (output start, first, block, input busy, done, digest);
  modport slave  (input start, first, block, output busy, done, digest);
`endif
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: one round per clock, rolling 16-word schedule,
// digest folding after round 63. Optional abort input with SHA256_CTRL_ABORT_EN.
module sha256_round_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ROUNDS     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sha256_round_ctrl_if.slave   bus
);
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  localparam int TW = $clog2(ROUNDS);

  localparam word_t K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Element [7] is H0 so the packed layout matches the digest bus directly.
  localparam logic [7:0][31:0] IV_WORDS = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  state_t              state_reg;
  logic [TW-1:0]       t_reg;
  logic                busy_reg;
  logic                done_reg;
  word_t               w_reg [16];
  word_t               v_reg [8];
  word_t               h_reg [8];
  word_t               v_next [8];
  word_t               k_reg;
  word_t               w_next;
  word_t               t1_next;
  word_t               t2_next;
  word_t               blk_word [16];
  word_t               iv_word [8];
  logic [15:0][31:0]   blk_words;
  wire  [7:0][31:0]    digest_words;
  logic [TW-1:0]       t_inc;
  logic [TW-1:0]       k_addr;
  logic                abort_hit;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign blk_words = bus.block;

  for (genvar gi = 0; gi < 16; gi++) begin : g_blk
    assign blk_word[gi] = blk_words[15-gi];
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_hash
    assign iv_word[gi]         = IV_WORDS[7-gi];
    assign digest_words[7-gi]  = h_reg[gi];
  end

  assign bus.digest = digest_words;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

  assign t_inc  = t_reg + TW'(1);
  // Prefetch K for the next round; in IDLE t_reg is 0 so K[0] is ready on entry.
  assign k_addr = (state_reg == ROUND) ? t_inc : '0;

  always_ff @(posedge clk) begin
    k_reg <= K_ROM[k_addr];
  end

  always_comb begin
    t1_next = v_reg[7]
            + (rotr(v_reg[4], 6) ^ rotr(v_reg[4], 11) ^ rotr(v_reg[4], 25))
            + ((v_reg[4] & v_reg[5]) ^ (~v_reg[4] & v_reg[6]))
            + k_reg + w_reg[0];
    t2_next = (rotr(v_reg[0], 2) ^ rotr(v_reg[0], 13) ^ rotr(v_reg[0], 22))
            + ((v_reg[0] & v_reg[1]) ^ (v_reg[0] & v_reg[2]) ^ (v_reg[1] & v_reg[2]));
    v_next[0] = t1_next + t2_next;
    v_next[1] = v_reg[0];
    v_next[2] = v_reg[1];
    v_next[3] = v_reg[2];
    v_next[4] = v_reg[3] + t1_next;
    v_next[5] = v_reg[4];
    v_next[6] = v_reg[5];
    v_next[7] = v_reg[6];
    w_next = (rotr(w_reg[14], 17) ^ rotr(w_reg[14], 19) ^ (w_reg[14] >> 10))
           + w_reg[9]
           + (rotr(w_reg[1], 7) ^ rotr(w_reg[1], 18) ^ (w_reg[1] >> 3))
           + w_reg[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        v_reg[i] <= '0;
        h_reg[i] <= iv_word[i];
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 16; i++) w_reg[i] <= blk_word[i];
            for (int i = 0; i < 8; i++) begin
              if (bus.first) begin
                h_reg[i] <= iv_word[i];
                v_reg[i] <= iv_word[i];
              end else begin
                v_reg[i] <= h_reg[i];
              end
            end
            t_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          if (abort_hit) begin
            t_reg     <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            for (int i = 0; i < 8; i++) v_reg[i] <= v_next[i];
            for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
            w_reg[15] <= w_next;
            t_reg     <= t_inc;
            if (t_reg == TW'(ROUNDS - 1)) state_reg <= FINAL;
          end
        end
        FINAL: begin
          if (abort_hit) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + v_reg[i];
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression function. Accepts one 512-bit message block and runs the combinational `sha256_single_iteration` round datapath 64 times, one round per clock. It generates W[t] through an on-the-fly message schedule, supplies K[t] from an internal 64-entry ROM, and holds the working variables a..h. After the last round it folds the result into the chaining digest, so multi-block messages hash by back-to-back starts.

## Interface
- `DATA_WIDTH`, 32, word width; only 32 is supported.
- `ROUNDS`, 64, rounds per block; only 64 is supported. Sizes the round counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to compress `block`; honoured only in IDLE.
- `first`  in  1  sampled with `start`. 1 = reload digest with the IV before this block; 0 = chain from the current digest.
- `block`  in  512  message block; `block[511:480]` = W0 … `block[31:0]` = W15. Sampled only on the accepting edge.
- `busy`  out  1  high from the cycle after acceptance until `done`, inclusive of the FINAL cycle.
- `done`  out  1  one-cycle pulse; `digest` is valid from this cycle.
- `digest`  out  256  H0..H7, with H0 in `[255:224]`. Holds its value between blocks.
- `abort`  in  1  present only with `SHA256_CTRL_ABORT_EN`.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE, on `start`=1:
  - Latch `block` into a 16-word W shift window.
  - If `first`=1, load H with the IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - Load a..h from the selected H (IV or current H).
  - Clear `t`; go to ROUND.
- ROUND:
  - Drive the datapath with W = window[0], K = K[t], and a..h.
  - Register a_out..h_out into a..h.
  - Shift the window by one word and append W[t+16] = σ1(W[t+14]) + W[t+9] + σ0(W[t+1]) + W[t]:
    - σ0 = ROTR7 ⊕ ROTR18 ⊕ SHR3.
    - σ1 = ROTR17 ⊕ ROTR19 ⊕ SHR10.
  - Increment `t`. After the round with t = 63, go to FINAL.
- FINAL: Hi ← Hi + working var i, for i = 0..7; go to DONE.
- DONE: assert `done`; go to IDLE.
- Arithmetic: all additions are modulo 2^32, and carries are discarded per word. `t` is 6 bits and wraps to 0 on leaving ROUND.
- `start` while not in IDLE is ignored; it is not queued. `start` in the DONE cycle is also ignored.
- `first` and `block` are don't-care except on the accepting edge.
- The K ROM holds the 64 standard SHA-256 constants (428a2f98, 71374491, … c67178f2).

## Timing
- Reset values, applied asynchronously:
  - State: IDLE.
  - `busy` = 0, `done` = 0, `t` = 0.
  - `digest` = IV; a..h and the W window = 0.
- Reset asserted mid-block returns to IDLE immediately. No `done` is issued, and `digest` returns to the IV.
- Latency: `start` accepted at edge E0 → rounds at E1..E64 → FINAL at E65 → `done` high in the cycle following E66.
- The next `start` is accepted one cycle after `done`. Minimum block period is 67 cycles.
- `busy` rises after E0 and falls with `done`.
- `digest` changes only at the FINAL edge, or at the accepting edge when `first`=1.

## Configuration
- `SHA256_CTRL_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 in ROUND or FINAL forces IDLE on the next edge. `done` is not pulsed, and `digest` keeps its pre-block value (the FINAL update is suppressed).
  - `abort` in IDLE or DONE has no effect.
  - `abort` has priority over a FINAL-state H update on the same edge.
- Undefined: no `abort` port; every accepted block runs to completion.

## Test plan
- "abc": `first`=1, block = 61626380 followed by 14 zero words and 00000018 → after 66 cycles `done` pulses with digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty string: `first`=1, block = 80000000 followed by 15 zero words → digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with `first`=1, then block 2 with `first`=0 issued one cycle after `done` → digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- `start` pulsed with a different block at cycles 10 and 40 of a running "abc" hash → ignored; "abc" digest unchanged; exactly one `done`.
- `rst` asserted at round 30 → `busy` = 0 and `digest` = IV immediately; a fresh "abc" afterwards yields the correct digest.
- With `SHA256_CTRL_ABORT_EN`: chain "abc" (first=1), start a second block, abort at round 20 → no `done`; `digest` still equals the "abc" digest; `busy` low on the next cycle.
